// File: rtl/btn_debounce.sv
// Push-button conditioner: polarity fix, 2-flop sync, debounce FSM, press/release/long pulses.
// Optional long-press detector enabled by defining BTN_DEBOUNCE_LONG_PRESS_EN.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int LONG_CYCLES     = 25000000,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          sync1;
  logic          sync2;
  logic          pin;

  // Normalise so that 1 always means pressed before the pin crosses into clk.
  assign pin = btn_in ^ ACTIVE_LOW;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (sync2) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync2) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state       <= PRESSED;
            cnt         <= '0;
            btn_level   <= 1'b1;
            press_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PRESSED: begin
          if (!sync2) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (sync2) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state         <= IDLE;
            cnt           <= '0;
            btn_level     <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
  localparam int LW = $clog2(LONG_CYCLES + 1);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
  localparam logic [LW-1:0] LONG_SAT  = LW'(LONG_CYCLES);

  logic [LW-1:0] lcnt;

  // Saturating at LONG_CYCLES keeps the pulse to one per hold; bounces through
  // RELEASE_WAIT keep counting so a chattering hold still qualifies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcnt       <= '0;
      long_pulse <= 1'b0;
    end else begin
      long_pulse <= 1'b0;
      if (state == PRESS_WAIT && sync2 && cnt == CNT_LAST) begin
        lcnt <= '0;
      end else if (state == PRESSED || state == RELEASE_WAIT) begin
        if (lcnt == LONG_LAST) long_pulse <= 1'b1;
        if (lcnt != LONG_SAT)  lcnt <= lcnt + LW'(1);
      end
    end
  end
`else
  assign long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Randomised scoreboard bench for btn_debounce: two instances (active-high and active-low pin)
// checked against a run-length reference model of the debounce rules.
module tb_btn_debounce;

  localparam int D = 4;
  localparam int L = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn = 1'b0;
  logic btn_n;
  assign btn_n = ~btn;

  logic lvl0, pr0, rl0, lg0;
  logic lvl1, pr1, rl1, lg1;

  btn_debounce #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .ACTIVE_LOW(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .btn_in(btn),
    .btn_level(lvl0), .press_pulse(pr0), .release_pulse(rl0), .long_pulse(lg0)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .ACTIVE_LOW(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_n),
    .btn_level(lvl1), .press_pulse(pr1), .release_pulse(rl1), .long_pulse(lg1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Expected events encoded as edge*4 + kind (0 press, 1 release, 2 long).
  int q0[$];
  int q1[$];

  // Reference model: the pin reaches the FSM two edges after sampling; a new
  // level is accepted once it has been seen there for D+1 consecutive edges.
  bit h0, h1, acc, armed, s2, fire_long, rel;
  int run, pc;

  function automatic void push_ev(input int k);
    q0.push_back(cyc * 4 + k);
    q1.push_back(cyc * 4 + k);
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      h0 = 0; h1 = 0; acc = 0; run = 0; armed = 0; pc = 0;
      q0.delete();
      q1.delete();
    end else begin
      s2 = h1;
      h1 = h0;
      h0 = btn;
      fire_long = 0;
      rel = 0;
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
      fire_long = armed && (cyc == pc + L);
`endif
      if (s2 != acc) run = run + 1;
      else run = 0;
      if (run == D + 1) begin
        acc = s2;
        run = 0;
        if (acc) begin
          push_ev(0);
          pc = cyc;
          armed = 1;
        end else begin
          push_ev(1);
          rel = 1;
        end
      end
      if (fire_long) begin
        push_ev(2);
        armed = 0;
      end
      if (rel) armed = 0;
    end
  end

  function automatic int qsize(input int id);
    return (id == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int qfront(input int id);
    return (id == 0) ? q0[0] : q1[0];
  endfunction

  function automatic int qpop(input int id);
    if (id == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  task automatic check_dut(input int id, input logic lvl, input logic pr, input logic rl, input logic lg);
    logic [2:0] bits;
    int e;
    bits = {lg, rl, pr};
    checks++;
    if (lvl !== acc) begin
      errors++;
      $display("FAIL level dut%0d edge %0d got %b want %b", id, cyc, lvl, acc);
    end
    for (int k = 0; k < 3; k++) begin
      if (bits[k] === 1'b1) begin
        checks++;
        if (qsize(id) == 0) begin
          errors++;
          $display("FAIL pulse dut%0d edge %0d got kind %0d want no event", id, cyc, k);
        end else begin
          e = qpop(id);
          if (e != cyc * 4 + k) begin
            errors++;
            $display("FAIL pulse dut%0d got kind %0d at edge %0d want kind %0d at edge %0d",
                     id, k, cyc, e % 4, e / 4);
          end
        end
      end
    end
    while (qsize(id) > 0 && qfront(id) < (cyc + 1) * 4) begin
      e = qpop(id);
      checks++;
      errors++;
      $display("FAIL missed dut%0d got none want kind %0d at edge %0d", id, e % 4, e / 4);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check_dut(0, lvl0, pr0, rl0, lg0);
      check_dut(1, lvl1, pr1, rl1, lg1);
    end
  end

  task automatic drive(input bit v, input int n);
    btn = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    logic [7:0] o;
    o = {lvl0, pr0, rl0, lg0, lvl1, pr1, rl1, lg1};
    checks++;
    if (o !== 8'h00) begin
      errors++;
      $display("FAIL %s outputs got %b want 00000000", tag, o);
    end
  endtask

  initial begin
    btn = 0;
    rst_n = 0;
    repeat (3) @(negedge clk);
    #1 check_zero("reset_state");
    #1 rst_n = 1;
    @(negedge clk);

    drive(0, 5);
    // clean press, release with bounce
    drive(1, 15);
    drive(0, 1); drive(1, 1); drive(0, 1); drive(1, 1);
    drive(0, 15);
    // short glitches
    drive(1, 1); drive(0, 4); drive(1, 2); drive(0, 4); drive(1, 3); drive(0, 10);
    // long hold
    drive(1, 40);
    drive(0, 15);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 2) == 0) drive(~btn, $urandom_range(1, 4));
      else drive(~btn, $urandom_range(5, 35));
    end
    drive(0, 15);

    // reset while pressed, then re-debounce with the button still held
    drive(1, 15);
    #2 rst_n = 0;
    #1 check_zero("reset_mid_press");
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    drive(1, 15);
    drive(0, 20);

    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d/%0d events want 0/0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
